fb_arbiter: RTL

Shares one single-port framebuffer RAM between two users: VGA scan-out, which has absolute priority, and a drawing-engine writer. The block sits between `vga_controller` (x, y) and the colour output stage, and fetches each 160x120 RGB332 framebuffer pixel in time for 4x4 upscaled display at 640x480. The writer gets every RAM cycle the display does not need, through a request/acknowledge handshake.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_prefetch_addr.sv | 57 +++++
 rtl/fb_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, VGA timing constants and pixel type for the
// framebuffer arbiter and its neighbours (vga_controller, colour stage).
package fb_pkg;

  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int SCALE_LOG2 = 2;
  localparam int DW         = 8;
  localparam int AW         = 15;

  localparam int H_ACTIVE   = 640;
  localparam int H_MAX      = 800;
  localparam int V_ACTIVE   = 480;
  localparam int V_MAX      = 525;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

endpackage

// File: rtl/fb_prefetch_addr.sv
// Looks two pixel clocks ahead of the scan position and derives the display
// read slot, the active-area flag and the framebuffer read address.
module fb_prefetch_addr
  import fb_pkg::*;
#(
  parameter int FB_W       = fb_pkg::FB_W,
  parameter int SCALE_LOG2 = fb_pkg::SCALE_LOG2,
  parameter int AW         = fb_pkg::AW,
  parameter int H_ACTIVE   = fb_pkg::H_ACTIVE,
  parameter int H_MAX      = fb_pkg::H_MAX,
  parameter int V_ACTIVE   = fb_pkg::V_ACTIVE,
  parameter int V_MAX      = fb_pkg::V_MAX
) (
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  output logic          slot,
  output logic          active,
  output logic [AW-1:0] rd_addr
);

  localparam logic [10:0] H_MAX_L = 11'(H_MAX);

  logic [10:0] x_ahead;
  logic [9:0]  px;
  logic [9:0]  py;
  logic [15:0] row;
  logic [15:0] col;
  logic [15:0] row_base;

  assign x_ahead = {1'b0, x} + 11'd2;

  always_comb begin
    px = x_ahead[9:0];
    py = y;
    if (x_ahead >= H_MAX_L) begin
      px = 10'(x_ahead - H_MAX_L);
      py = (y == 10'(V_MAX - 1)) ? 10'd0 : y + 10'd1;
    end
  end

  assign active = (px < 10'(H_ACTIVE)) && (py < 10'(V_ACTIVE));
  assign slot   = active && (px[SCALE_LOG2-1:0] == '0);

  assign row = 16'(py >> SCALE_LOG2);
  assign col = 16'(px >> SCALE_LOG2);

  // Constant row stride built from shifted copies of the row index only.
  always_comb begin
    row_base = '0;
    for (int i = 0; i < 16; i++) begin
      if (FB_W[i]) row_base = row_base + (row << i);
    end
  end

  assign rd_addr = AW'(row_base + col);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: VGA scan-out reads take absolute
// priority, the drawing-engine writer gets every remaining cycle.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int FB_W       = fb_pkg::FB_W,
  parameter int FB_H       = fb_pkg::FB_H,
  parameter int SCALE_LOG2 = fb_pkg::SCALE_LOG2,
  parameter int DW         = fb_pkg::DW,
  parameter int AW         = fb_pkg::AW,
  parameter int H_ACTIVE   = fb_pkg::H_ACTIVE,
  parameter int H_MAX      = fb_pkg::H_MAX,
  parameter int V_ACTIVE   = fb_pkg::V_ACTIVE,
  parameter int V_MAX      = fb_pkg::V_MAX
) (
  input  logic          vga_clk,
  input  logic          rst,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          wr_oob,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid
);

  localparam logic [AW-1:0] FB_SIZE = AW'(FB_W * FB_H);

  logic          slot;
  logic          active;
  logic [AW-1:0] rd_addr;
  logic          rd_go;
  logic          wr_go;
  logic          wr_bad;
  logic          rd_pend;
  logic [1:0]    valid_q;
  logic [DW-1:0] pix_q;

  fb_prefetch_addr #(
    .FB_W       (FB_W),
    .SCALE_LOG2 (SCALE_LOG2),
    .AW         (AW),
    .H_ACTIVE   (H_ACTIVE),
    .H_MAX      (H_MAX),
    .V_ACTIVE   (V_ACTIVE),
    .V_MAX      (V_MAX)
  ) u_prefetch (
    .x       (x),
    .y       (y),
    .slot    (slot),
    .active  (active),
    .rd_addr (rd_addr)
  );

  // Blocking writes in the ack cycle keeps a held request from issuing twice.
  assign rd_go  = rst && slot;
  assign wr_go  = rst && wr_req && !slot && !wr_ack;
  assign wr_bad = wr_addr >= FB_SIZE;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rd_go) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end else if (wr_go && !wr_bad) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end
  end

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      wr_ack  <= 1'b0;
      wr_oob  <= 1'b0;
      rd_pend <= 1'b0;
      valid_q <= '0;
      pix_q   <= '0;
    end else begin
      wr_ack  <= wr_go;
      wr_oob  <= wr_oob || (wr_go && wr_bad);
      rd_pend <= rd_go;
      valid_q <= {valid_q[0], active};
      if (rd_pend) pix_q <= mem_rdata;
    end
  end

  assign pix_valid = valid_q[1];
  assign pix_data  = valid_q[1] ? pix_q : '0;

endmodule
